// File: rtl/trap_ctrl_pkg.sv
// ------------------------------------------------------------------------
// trap_ctrl_pkg : SYSTEM decode constants, trap cause codes, FSM encoding.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package trap_ctrl_pkg;

  localparam logic [4:0]  OP_SYSTEM   = 5'b11100;
  localparam logic [2:0]  F3_PRIV     = 3'b000;
  // ir[21] separates MRET (1) from ECALL (0) inside the privileged group
  localparam int          MRET_BIT    = 21;

  localparam logic [31:0] CAUSE_ECALL = 32'h0000000B;
  localparam logic [31:0] CAUSE_MTI   = 32'h80000007;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_timer_cmp.sv
// ------------------------------------------------------------------------
// trap_ctrl_timer_cmp : mtimecmp register, arm flag, wrap-safe compare.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module trap_ctrl_timer_cmp #(
  parameter logic [31:0] TIMECMP_RST = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mcycle,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic        mie,
  input  logic        take,
  output logic        irq_pend
);

  logic [31:0] mtimecmp;
  logic        armed;
  logic [31:0] delta;

  // A fresh compare write re-arms even if an interrupt is taken that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= TIMECMP_RST;
      armed    <= 1'b0;
    end else if (cmp_we) begin
      mtimecmp <= cmp_wdata;
      armed    <= 1'b1;
    end else if (take) begin
      armed    <= 1'b0;
    end
  end

  // Sign of the difference survives mcycle wrapping past zero
  assign delta    = mcycle - mtimecmp;
  assign irq_pend = armed && mie && !delta[31];

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ------------------------------------------------------------------------
// trap_ctrl : ECALL/MRET/timer trap sequencer (flush, drain, redirect).
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] BOOT        = 32'h00000000,
  parameter logic [31:0] TIMECMP_RST = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_valid,
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] mcycle,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic        drain_done,
  input  logic        redirect_ready,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_we,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_cause,
  output logic        mie
);

  state_t      state;
  logic [31:0] target;
  logic [31:0] last_pc;
  logic        is_sys;
  logic        do_ecall;
  logic        do_mret;
  logic        irq_pend;
  logic        take_irq;

  assign is_sys   = (ir[6:2] == OP_SYSTEM) && (ir[14:12] == F3_PRIV);
  assign do_ecall = (state == S_IDLE) && ir_valid && is_sys && (ir[MRET_BIT] == 1'b0);
  assign do_mret  = (state == S_IDLE) && ir_valid && is_sys && (ir[MRET_BIT] == 1'b1);
  // An instruction event in the same cycle wins; the interrupt stays pending
  assign take_irq = (state == S_IDLE) && irq_pend && !do_ecall && !do_mret;

  trap_ctrl_timer_cmp #(
    .TIMECMP_RST (TIMECMP_RST)
  ) u_timer_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .mcycle    (mcycle),
    .cmp_we    (cmp_we),
    .cmp_wdata (cmp_wdata),
    .mie       (mie),
    .take      (take_irq),
    .irq_pend  (irq_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= BOOT;
      trap_we        <= 1'b0;
      trap_epc       <= 32'h0;
      trap_cause     <= 32'h0;
      mie            <= 1'b0;
      target         <= 32'h0;
      last_pc        <= 32'h0;
    end else begin
      if (ir_valid) last_pc <= pc;
      unique case (state)
        S_IDLE: begin
          if (do_ecall || take_irq) begin
            state      <= S_FLUSH;
            busy       <= 1'b1;
            flush      <= 1'b1;
            trap_we    <= 1'b1;
            trap_epc   <= ir_valid ? pc : last_pc;
            trap_cause <= do_ecall ? CAUSE_ECALL : CAUSE_MTI;
            target     <= mtvec & ~32'h3;
            mie        <= 1'b0;
          end else if (do_mret) begin
            state      <= S_FLUSH;
            busy       <= 1'b1;
            flush      <= 1'b1;
            target     <= mepc;
            mie        <= 1'b1;
          end
        end
        S_FLUSH: begin
          flush   <= 1'b0;
          trap_we <= 1'b0;
          state   <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state          <= S_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ------------------------------------------------------------------------
// tb_trap_ctrl : directed self-checking bench for trap_ctrl.
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_trap_ctrl;

  localparam logic [31:0] BOOT_V  = 32'h00001000;
  localparam logic [31:0] ECALL_I = 32'h00000073;
  localparam logic [31:0] MRET_I  = 32'h30200073;
  localparam logic [31:0] C_EC    = 32'h0000000B;
  localparam logic [31:0] C_MTI   = 32'h80000007;

  logic        clk = 1'b0;
  logic        rst_n, ir_valid, cmp_we, drain_done, redirect_ready;
  logic [31:0] ir, pc, mtvec, mepc, mcycle, cmp_wdata;
  logic        busy, flush, redirect_valid, trap_we, mie;
  logic [31:0] redirect_pc, trap_epc, trap_cause;
  logic        mc_load;
  logic [31:0] mc_val;
  int          checks = 0;
  int          failures = 0;

  trap_ctrl #(.BOOT(BOOT_V), .TIMECMP_RST(32'hFFFFFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir(ir), .pc(pc),
    .mtvec(mtvec), .mepc(mepc), .mcycle(mcycle), .cmp_we(cmp_we),
    .cmp_wdata(cmp_wdata), .drain_done(drain_done), .redirect_ready(redirect_ready),
    .busy(busy), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_we(trap_we), .trap_epc(trap_epc),
    .trap_cause(trap_cause), .mie(mie)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mc_load) mcycle <= mc_val;
    else         mcycle <= mcycle + 32'd1;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_rv got=%0h exp=0", redirect_valid); end
    checks++; if (trap_we !== 1'b0) begin failures++; $display("FAIL rst_twe got=%0h exp=0", trap_we); end
    checks++; if (redirect_pc !== BOOT_V) begin failures++; $display("FAIL rst_rpc got=%h exp=%h", redirect_pc, BOOT_V); end
    checks++; if (trap_epc !== 32'h0) begin failures++; $display("FAIL rst_epc got=%h exp=0", trap_epc); end
    checks++; if (trap_cause !== 32'h0) begin failures++; $display("FAIL rst_cause got=%h exp=0", trap_cause); end
    checks++; if (mie !== 1'b0) begin failures++; $display("FAIL rst_mie got=%0h exp=0", mie); end
    rst_n = 1'b1;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_irq got=%0h exp=0", busy); end
  endtask

  task automatic test_ecall();
    ir = ECALL_I; pc = 32'h100; mtvec = 32'h203; drain_done = 1'b1; redirect_ready = 1'b1; ir_valid = 1'b1;
    cyc(); ir_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ecall_flush got=%0h exp=1", flush); end
    checks++; if (trap_we !== 1'b1) begin failures++; $display("FAIL ecall_twe got=%0h exp=1", trap_we); end
    checks++; if (trap_epc !== 32'h100) begin failures++; $display("FAIL ecall_epc got=%h exp=00000100", trap_epc); end
    checks++; if (trap_cause !== C_EC) begin failures++; $display("FAIL ecall_cause got=%h exp=%h", trap_cause, C_EC); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ecall_busy got=%0h exp=1", busy); end
    checks++; if (mie !== 1'b0) begin failures++; $display("FAIL ecall_mie got=%0h exp=0", mie); end
    cyc();
    checks++; if (flush !== 1'b0 || trap_we !== 1'b0) begin failures++; $display("FAIL ecall_pulse flush=%0h twe=%0h exp=0/0", flush, trap_we); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL ecall_rv_early got=%0h exp=0", redirect_valid); end
    cyc();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL ecall_rv got=%0h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL ecall_rpc got=%h exp=00000200", redirect_pc); end
    cyc();
    checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL ecall_done busy=%0h rv=%0h exp=0/0", busy, redirect_valid); end
  endtask

  task automatic test_mret();
    ir = MRET_I; pc = 32'h180; mepc = 32'h104; ir_valid = 1'b1;
    cyc(); ir_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mret_flush got=%0h exp=1", flush); end
    checks++; if (trap_we !== 1'b0) begin failures++; $display("FAIL mret_twe got=%0h exp=0", trap_we); end
    checks++; if (mie !== 1'b1) begin failures++; $display("FAIL mret_mie got=%0h exp=1", mie); end
    repeat (2) cyc();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin failures++; $display("FAIL mret_redirect rv=%0h pc=%h exp=1/00000104", redirect_valid, redirect_pc); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mret_done got=%0h exp=0", busy); end
  endtask

  // Issues MRET from IDLE and expects it to be the only flush in the window
  task automatic mret_no_repeat(input logic [31:0] mret_pc, input string tag);
    int n;
    n = 0;
    ir = MRET_I; pc = mret_pc; ir_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(); ir_valid = 1'b0;
      if (flush === 1'b1) n++;
    end
    checks++; if (n != 1) begin failures++; $display("FAIL %s_no_repeat flushes=%0d exp=1", tag, n); end
    checks++; if (mie !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL %s_rearm mie=%0h busy=%0h exp=1/0", tag, mie, busy); end
  endtask

  task automatic test_timer();
    int n, first;
    logic [31:0] cs, es;
    n = 0; first = 0; cs = '0; es = '0;
    cmp_wdata = mcycle + 32'd20; cmp_we = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(); cmp_we = 1'b0;
      if (flush === 1'b1) begin
        n++;
        if (first == 0) begin first = i; cs = trap_cause; es = trap_epc; end
      end
    end
    checks++; if (n != 1) begin failures++; $display("FAIL timer_count got=%0d exp=1", n); end
    checks++; if (first != 21) begin failures++; $display("FAIL timer_cycle got=%0d exp=21", first); end
    checks++; if (cs !== C_MTI) begin failures++; $display("FAIL timer_cause got=%h exp=%h", cs, C_MTI); end
    checks++; if (es !== 32'h180) begin failures++; $display("FAIL timer_epc got=%h exp=00000180", es); end
    checks++; if (mie !== 1'b0) begin failures++; $display("FAIL timer_mie got=%0h exp=0", mie); end
    mret_no_repeat(32'h1C0, "timer");
  endtask

  task automatic test_wrap();
    int n, first;
    logic [31:0] cs, es;
    n = 0; first = 0; cs = '0; es = '0;
    mc_val = 32'hFFFFFFF0; mc_load = 1'b1; cmp_wdata = 32'h5; cmp_we = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(); mc_load = 1'b0; cmp_we = 1'b0;
      if (flush === 1'b1) begin
        n++;
        if (first == 0) begin first = i; cs = trap_cause; es = trap_epc; end
      end
    end
    checks++; if (first != 23) begin failures++; $display("FAIL wrap_cycle got=%0d exp=23", first); end
    checks++; if (n != 1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", n); end
    checks++; if (cs !== C_MTI || es !== 32'h1C0) begin failures++; $display("FAIL wrap_data cause=%h epc=%h exp=%h/000001c0", cs, es, C_MTI); end
    mret_no_repeat(32'h1C4, "wrap");
  endtask

  task automatic test_priority();
    cmp_wdata = mcycle; cmp_we = 1'b1;
    cyc(); cmp_we = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_pre got=%0h exp=0", busy); end
    ir = ECALL_I; pc = 32'h300; ir_valid = 1'b1;
    cyc(); ir_valid = 1'b0;
    checks++; if (trap_cause !== C_EC || trap_epc !== 32'h300 || trap_we !== 1'b1) begin failures++; $display("FAIL prio_ecall cause=%h epc=%h twe=%0h exp=%h/00000300/1", trap_cause, trap_epc, trap_we, C_EC); end
    repeat (3) cyc();
    checks++; if (busy !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL prio_masked busy=%0h flush=%0h exp=0/0", busy, flush); end
    ir = MRET_I; pc = 32'h308; mepc = 32'h304; ir_valid = 1'b1;
    cyc(); ir_valid = 1'b0;
    checks++; if (flush !== 1'b1 || trap_we !== 1'b0) begin failures++; $display("FAIL prio_mret flush=%0h twe=%0h exp=1/0", flush, trap_we); end
    repeat (2) cyc();
    checks++; if (redirect_pc !== 32'h304 || redirect_valid !== 1'b1) begin failures++; $display("FAIL prio_mret_rpc pc=%h rv=%0h exp=00000304/1", redirect_pc, redirect_valid); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_idle got=%0h exp=0", busy); end
    cyc();
    checks++; if (flush !== 1'b1 || trap_we !== 1'b1) begin failures++; $display("FAIL prio_irq flush=%0h twe=%0h exp=1/1", flush, trap_we); end
    checks++; if (trap_cause !== C_MTI || trap_epc !== 32'h308) begin failures++; $display("FAIL prio_irq_data cause=%h epc=%h exp=%h/00000308", trap_cause, trap_epc, C_MTI); end
    checks++; if (mie !== 1'b0) begin failures++; $display("FAIL prio_irq_mie got=%0h exp=0", mie); end
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_end got=%0h exp=0", busy); end
  endtask

  task automatic test_backpressure();
    redirect_ready = 1'b0;
    ir = ECALL_I; pc = 32'h400; ir_valid = 1'b1;
    cyc(); ir_valid = 1'b0;
    repeat (2) cyc();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin failures++; $display("FAIL bp_start rv=%0h pc=%h exp=1/00000200", redirect_valid, redirect_pc); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (redirect_valid !== 1'b1 || busy !== 1'b1 || redirect_pc !== 32'h200) begin failures++; $display("FAIL bp_hold%0d rv=%0h busy=%0h pc=%h exp=1/1/00000200", i, redirect_valid, busy, redirect_pc); end
    end
    redirect_ready = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL bp_accept busy=%0h rv=%0h exp=0/0", busy, redirect_valid); end
    redirect_ready = 1'b0;
    ir = ECALL_I; pc = 32'h500; ir_valid = 1'b1;
    cyc(); ir_valid = 1'b0;
    repeat (4) cyc();
    checks++; if (redirect_valid !== 1'b1 || trap_epc !== 32'h500) begin failures++; $display("FAIL bp2_stall rv=%0h epc=%h exp=1/00000500", redirect_valid, trap_epc); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0 || trap_we !== 1'b0) begin failures++; $display("FAIL async_rst_ctl busy=%0h rv=%0h flush=%0h twe=%0h exp=0/0/0/0", busy, redirect_valid, flush, trap_we); end
    checks++; if (redirect_pc !== BOOT_V || trap_epc !== 32'h0 || trap_cause !== 32'h0 || mie !== 1'b0) begin failures++; $display("FAIL async_rst_data pc=%h epc=%h cause=%h mie=%0h exp=%h/0/0/0", redirect_pc, trap_epc, trap_cause, mie, BOOT_V); end
    cyc();
    rst_n = 1'b1; redirect_ready = 1'b1;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== BOOT_V) begin failures++; $display("FAIL post_rst busy=%0h rv=%0h pc=%h exp=0/0/%h", busy, redirect_valid, redirect_pc, BOOT_V); end
  endtask

  initial begin
    rst_n = 1'b0; ir_valid = 1'b0; ir = '0; pc = '0; mtvec = '0; mepc = '0;
    cmp_we = 1'b0; cmp_wdata = '0; drain_done = 1'b0; redirect_ready = 1'b0;
    mc_load = 1'b1; mc_val = 32'h0;
    cyc(); mc_load = 1'b0;
    test_reset();
    test_ecall();
    test_mret();
    test_timer();
    test_wrap();
    test_priority();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer on the consumer side of the CSR file. It watches the issuing instruction for ECALL/MRET and a machine-timer compare against mcycle, then sequences flush, drain and PC redirect. It writes back mepc/mcause and redirects fetch to mtvec or mepc. It sits between the CSR file and the fetch stage, and stalls issue while a trap is in flight.

## Interface
Parameters:
- BOOT, 32'h00000000, reset value of redirect_pc.
- TIMECMP_RST, 32'hFFFFFFFF, reset value of mtimecmp.

Ports:
- clk  in  1  Clock; one clock domain, all logic on the rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- ir_valid  in  1  Issue stage presents ir/pc this cycle.
- ir  in  32  Instruction word at issue.
- pc  in  32  PC of ir.
- mtvec  in  32  From the CSR file.
- mepc  in  32  From the CSR file.
- mcycle  in  32  Free-running cycle count from the CSR file.
- cmp_we  in  1  Write strobe for mtimecmp; also arms the timer.
- cmp_wdata  in  32  mtimecmp write data.
- drain_done  in  1  Pipeline reports it is empty after a flush.
- redirect_ready  in  1  Fetch accepts the redirect.
- busy  out  1  High whenever state is not IDLE; issue must stall.
- flush  out  1  One-cycle pulse that kills younger instructions.
- redirect_valid  out  1  Redirect request, held until accepted.
- redirect_pc  out  32  Redirect target.
- trap_we  out  1  One-cycle pulse telling the CSR file to write mepc/mcause.
- trap_epc  out  32  Value for mepc.
- trap_cause  out  32  Value for mcause.
- mie  out  1  Global machine interrupt enable.

## Operation
- Decode: SYSTEM means ir[6:2]=5'b11100 and ir[14:12]=0. Within SYSTEM, ir[21]=0 is ECALL and ir[21]=1 is MRET. All other instructions are ignored.
- Timer: irq_pend = armed && mie && ($signed(mcycle - mtimecmp) >= 0). The comparison is wrap-safe across mcycle overflow. cmp_we loads mtimecmp and sets armed. Taking the interrupt clears armed.
- FSM states: IDLE, FLUSH, DRAIN, REDIRECT.
- IDLE to FLUSH on an accepted event. An event is accepted when:
  - ir_valid and the instruction is ECALL or MRET, or
  - irq_pend (instruction accepted or not).
- Event data latched at acceptance:
  - ECALL: epc=pc, cause=32'h0000000B, target=mtvec&~3, mie cleared.
  - IRQ: epc=pc if ir_valid, otherwise the last valid pc. cause=32'h80000007, target=mtvec&~3, mie cleared, armed cleared.
  - MRET: target=mepc, mie set, no CSR write.
- Priority when ECALL/MRET and irq_pend occur in the same cycle: the instruction wins. The interrupt stays pending and is re-evaluated in the next IDLE cycle; after MRET it is taken immediately because mie becomes 1.
- FLUSH: flush=1 for exactly this cycle. trap_we=1 in the same cycle for ECALL/IRQ. Always moves to DRAIN.
- DRAIN: waits for drain_done, then moves to REDIRECT. If drain_done is already high on entry, the wait is 1 cycle.
- REDIRECT: redirect_valid=1 and redirect_pc=target, held stable until redirect_ready. Returns to IDLE on the handshake.
- cmp_we is accepted in any state. irq_pend is never sampled outside IDLE.

## Timing
- Reset values:
  - state=IDLE; busy=0, flush=0, redirect_valid=0, trap_we=0.
  - redirect_pc=BOOT, trap_epc=0, trap_cause=0.
  - mie=0, armed=0, mtimecmp=TIMECMP_RST.
- Latency: event in cycle N gives flush/trap_we in N+1 and busy from N+1. With drain_done held high, redirect_valid is first high in N+3.
- Minimum event-to-event period is 4 cycles.
- All outputs are registered.
- Reset asserted mid-sequence returns to IDLE immediately. No redirect completes.
- redirect_pc must not change while redirect_valid=1 and redirect_ready=0.

## Structure
- Shared package/include holds:
  - SYSTEM opcode, funct3 and ECALL/MRET discriminator constants.
  - Cause codes 32'hB and 32'h80000007.
  - FSM state encoding.
- One natural sub-module: timer_cmp, containing mtimecmp, armed and the wrap-safe comparator.

## Test plan
- ECALL 32'h00000073 at pc=32'h100, mtvec=32'h203, drain_done=1, redirect_ready=1 -> flush and trap_we at N+1 with epc=32'h100, cause=32'hB; redirect_pc=32'h200 at N+3; mie=0.
- MRET 32'h30200073 with mepc=32'h104 -> redirect_pc=32'h104; no trap_we; mie=1.
- mie=1, cmp_wdata=mcycle+20 -> exactly one interrupt about 20 cycles later with cause=32'h80000007; armed cleared so there is no repeat.
- mtimecmp=32'h00000005 while mcycle=32'hFFFFFFF0 -> no interrupt until mcycle wraps past 5.
- ECALL and irq_pend in the same cycle, then MRET -> ECALL serviced first; interrupt taken directly after MRET returns to IDLE.
- redirect_ready held low 5 cycles, with rst_n pulsed low in a second run -> redirect_pc stable and busy=1 throughout; after reset, all outputs return to reset values asynchronously.
